// File: rtl/fetch_address.sv
// Program counter and single memory bus arbiter sitting in front of fetchstage0.
// Muxes fetch vs. data accesses, handles redirects, halt freeze and fetch/stall counting.
module fetch_address #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        halting,
  input  logic        data_request,
  input  logic [31:0] data_address,
  input  logic        data_write,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] mem_address,
  output logic        mem_write,
  output logic        block_fetch,
  output logic [31:0] outbound_pc,
  output logic        halted,
  output logic        align_fault,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count,
  output logic        dbg_state
);

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] outbound_pc_q, outbound_pc_d;
  logic        align_fault_q, align_fault_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] stall_count_q, stall_count_d;

  logic run;
  logic redirect;

  assign run      = (state_q == RUN);
  assign redirect = branch_taken && run;

  // A request is dropped outright while reset is low, so no write can leak out.
  always_comb begin
    mem_address = pc_q;
    mem_write   = 1'b0;
    if (reset && data_request) begin
      mem_address = data_address;
      mem_write   = data_write;
    end
  end

  assign block_fetch = !reset || data_request || branch_taken || !run;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    outbound_pc_d = outbound_pc_q;
    align_fault_d = align_fault_q;
    fetch_count_d = fetch_count_q;
    stall_count_d = stall_count_q;

    // Request and redirect in the same cycle still cost a single stall.
    if (run && (data_request || branch_taken)) begin
      stall_count_d = stall_count_q + 32'd1;
    end

    if (redirect) begin
      pc_d = {branch_target[31:2], 2'b00};
      if (branch_target[1:0] != 2'b00) begin
        align_fault_d = 1'b1;
      end
    end

    if (run && halting) begin
      state_d = HALTED;
    end else if (run && !data_request && !branch_taken) begin
      outbound_pc_d = pc_q;
      pc_d          = pc_q + 32'd4;
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= RUN;
      pc_q          <= RESET_VECTOR;
      outbound_pc_q <= 32'd0;
      align_fault_q <= 1'b0;
      fetch_count_q <= 32'd0;
      stall_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      outbound_pc_q <= outbound_pc_d;
      align_fault_q <= align_fault_d;
      fetch_count_q <= fetch_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign outbound_pc = outbound_pc_q;
  assign halted      = (state_q == HALTED);
  assign align_fault = align_fault_q;
  assign fetch_count = fetch_count_q;
  assign stall_count = stall_count_q;
  assign dbg_state   = state_q;

endmodule
